ihex_loader: RTL and testbench
==============================

# ihex_loader

Streaming Intel HEX / raw-binary program loader between the HPS download port and the AVR program ROM write port. It consumes the byte stream delivered by hps_io during an OSD file load and parses ASCII Intel HEX records, producing one byte-wide ROM write per decoded data byte. Raw `.BIN` images pass through unchanged. The block replaces the inline parser in `emu`, adds checksum verification, lowercase hex support and load status, and runs on `clk_sys`.

## Interface
- `ADDR_W`, default 15: ROM byte-address width; 32 KB program flash.
- `clk`  in  1  system clock (`clk_sys`).
- `rst`  in  1  synchronous, active-high reset.
- `dl_active`  in  1  download in progress (`ioctl_download`).
- `dl_hex`  in  1  stream is Intel HEX (`ioctl_index != 0`); sampled on `dl_active` rising edge.
- `dl_wr`  in  1  one-cycle strobe, `dl_addr`/`dl_data` valid.
- `dl_addr`  in  ADDR_W  byte offset of `dl_data` in file.
- `dl_data`  in  8  file byte.
- `rom_we`  out  1  one-cycle ROM byte write strobe.
- `rom_addr`  out  ADDR_W  byte address; bit 0 selects the high byte of the 16-bit word.
- `rom_data`  out  8  byte to write.
- `busy`  out  1  parser is inside a record.
- `done`  out  1  EOF record (type 01) accepted with a good checksum.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  0 none, 1 bad character, 2 checksum mismatch, 3 unsupported record type.
- `rec_count`  out  16  number of records accepted with a good checksum.

## Operation
- **Raw mode** (`dl_hex`=0 latched):
  - `rom_we`=`dl_wr`, `rom_addr`=`dl_addr`, `rom_data`=`dl_data`, all registered.
  - Parser idle; `done`, `err` and `rec_count` stay 0.
- **Hex mode** state machine, advanced only on `dl_wr`:
  - `IDLE`: `:` → `LEN_H`. CR, LF, space → stay. Any other byte → set `err` (code 1) and stay.
  - `LEN_H`, `LEN_L`: 8-bit byte count `cnt`.
  - `ADR_3`..`ADR_0`: 16-bit record address `addr`.
  - `TYP_H`, `TYP_L`: record type.
  - After `TYP_L`: `cnt`=0 → `CSUM_H`; otherwise → `DAT_H`.
  - `DAT_H`, `DAT_L` repeat `cnt` times. Each completed byte is written only for type 00, then `addr` increments.
  - `CSUM_H`, `CSUM_L` → check, then `IDLE`.
- **Nibble decode**: `0`–`9`, `A`–`F`, `a`–`f`. Any other byte outside `IDLE` → `err`=1, code 1, state → `IDLE`, record abandoned.
- **Checksum**:
  - 8-bit running sum of all decoded bytes (len, addr hi/lo, type, data, checksum); wraps mod 256.
  - Record is good iff the sum is 0 after `CSUM_L`.
  - Good record: `rec_count` += 1, saturating at 0xFFFF.
  - Bad record: `err`=1, code 2.
- **Record types**:
  - 00: data, written.
  - 01: EOF; if good, `done`=1.
  - 02–05: parsed and checked, data discarded, no writes.
  - ≥06: code 3 at `TYP_L`; record still parsed to `CSUM_L`, no writes.
- **Writes are not rolled back.** Data bytes of a record later failing checksum remain in ROM; `err` reports it.
- `rom_addr` = `addr[ADDR_W-1:0]`. Addresses ≥ 2^ADDR_W alias (wrap); no error.
- `err_code` holds the first error; later errors do not overwrite it.
- Bytes after `done` are still parsed; `done` stays set.
- `busy`=1 in every state except `IDLE`.

## Timing
- Reset: all outputs 0, state `IDLE`, sum 0, latched mode raw.
- `dl_active` rising edge:
  - latch `dl_hex`;
  - clear `done`, `err`, `err_code`, `rec_count`, sum;
  - state ← `IDLE`.
- `dl_active` low: state forced to `IDLE` every cycle; `done`/`err`/`rec_count` hold for the host to read.
- Write latency: `rom_we` asserts exactly 1 cycle after the `dl_wr` that delivers the last needed byte (raw byte or `DAT_L` nibble). Pulse width is 1 cycle.
- Back-to-back `dl_wr` on consecutive cycles must be accepted without loss; minimum gap is 0.
- Status latency:
  - `done`, `err` (code 2) and `rec_count` update 1 cycle after the `CSUM_L` strobe.
  - Code 1/3 errors appear 1 cycle after the offending strobe.
- `rst` mid-record: abandon immediately, no further `rom_we`.
- `dl_active` falling mid-record: state → `IDLE` next cycle, no error flagged.

## Structure
- Package `ihex_pkg`:
  - state enum `ihex_state_t`;
  - record-type constants `REC_DATA`=8'h00, `REC_EOF`=8'h01;
  - error-code constants `ERR_NONE`, `ERR_CHAR`, `ERR_CSUM`, `ERR_TYPE`.
- One sub-module, `ascii_hex_nibble`: combinational byte → {valid, nibble[3:0]}. It is shared by all digit states.
- Top `ihex_loader` holds the FSM, nibble-pair assembly register, counters and status.

## Test plan
- Raw mode, bytes 0x11,0x22 at `dl_addr` 0,1 → `rom_we` twice, addr 0/1, data 0x11/0x22, 1-cycle latency, `done`=0.
- Hex `:0401000001020304F1` then `:00000001FF` → writes 0x01..0x04 at 0x0100..0x0103, `rec_count`=2, `done`=1, `err`=0.
- Same data record with lowercase digits and CRLF between records, strobes on consecutive cycles → identical writes, no error.
- `:0401000001020304F2` → 4 writes occur, then `err`=1, `err_code`=2, `rec_count`=0, `done`=0.
- `:04010G` → `err_code`=1 one cycle after the `G` strobe, state `IDLE`, no writes. A following valid EOF record sets `done`=1 while `err` stays 1.
- Record type 06 (`:0000000AF6`) → `err_code`=3 after `TYP_L`, no writes, record still counted since checksum is good. Separately, `rst` pulsed mid-record → all outputs 0, no further writes.

Source files
------------

// File: rtl/ihex_pkg.sv
// Shared types and constants for the Intel HEX loader.
//   ihex_state_t : parser state, one state per ASCII digit position of a record
//   REC_*        : record type values the parser acts on
//   ERR_*        : err_code values
//   CH_*         : framing characters recognised between records
package ihex_pkg;

  typedef enum logic [3:0] {
    IDLE, LEN_H, LEN_L, ADR_3, ADR_2, ADR_1, ADR_0,
    TYP_H, TYP_L, DAT_H, DAT_L, CSUM_H, CSUM_L
  } ihex_state_t;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;
  localparam logic [7:0] REC_LAST = 8'h05;  // highest supported record type

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TYPE = 2'd3;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;

  function automatic logic is_blank(input logic [7:0] ch);
    return (ch == CH_CR) || (ch == CH_LF) || (ch == CH_SP);
  endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII hex digit decoder.
//   ch    : input byte
//   valid : ch is 0-9, A-F or a-f
//   nib   : decoded value (0 when not valid)
module ascii_hex_nibble (
  input  logic [7:0] ch,
  output logic       valid,
  output logic [3:0] nib
);

  always_comb begin
    valid = 1'b1;
    nib   = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so add 9 to land on 10
      nib = ch[3:0] + 4'd9;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/ihex_loader.sv
// Streaming Intel HEX / raw binary loader from the HPS download port to the
// program ROM byte write port.
//   clk, rst                  : clock, synchronous active-high reset
//   dl_active, dl_hex         : download window, stream format (latched at start)
//   dl_wr, dl_addr, dl_data   : download byte strobe, file offset, file byte
//   rom_we, rom_addr, rom_data: registered one-cycle ROM byte write
//   busy                      : parser inside a record
//   done, err, err_code       : EOF seen / sticky error / first error cause
//   rec_count                 : records accepted with a good checksum (saturating)
module ihex_loader
  import ihex_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dl_active,
  input  logic              dl_hex,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       rec_count
);

  ihex_state_t state, state_next;
  logic        active_q, hex_mode, active_rise, hex_strobe;
  logic        nib_ok;
  logic [3:0]  nib, hi_nib;
  logic [7:0]  cnt, rtype, sum, byte_val, sum_new;
  logic [15:0] addr;
  logic        bad_char, type_bad, data_wr, rec_end, csum_bad;

  ascii_hex_nibble u_nib (
    .ch    (dl_data),
    .valid (nib_ok),
    .nib   (nib)
  );

  // The rising-edge cycle only latches the mode; strobes are taken from the
  // following cycle onwards.
  assign active_rise = dl_active & ~active_q;
  assign hex_strobe  = dl_active & ~active_rise & hex_mode & dl_wr;
  assign byte_val    = {hi_nib, nib};
  assign sum_new     = sum + byte_val;
  assign csum_bad    = rec_end && (sum_new != 8'd0);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bad_char   = 1'b0;
    type_bad   = 1'b0;
    data_wr    = 1'b0;
    rec_end    = 1'b0;
    if (!dl_active || active_rise) begin
      state_next = IDLE;
    end else if (hex_strobe) begin
      if (state == IDLE) begin
        if (dl_data == CH_COLON)     state_next = LEN_H;
        else if (!is_blank(dl_data)) bad_char   = 1'b1;
      end else if (!nib_ok) begin
        bad_char   = 1'b1;
        state_next = IDLE;
      end else begin
        case (state)
          LEN_H:  state_next = LEN_L;
          LEN_L:  state_next = ADR_3;
          ADR_3:  state_next = ADR_2;
          ADR_2:  state_next = ADR_1;
          ADR_1:  state_next = ADR_0;
          ADR_0:  state_next = TYP_H;
          TYP_H:  state_next = TYP_L;
          TYP_L: begin
            type_bad   = (byte_val > REC_LAST);
            state_next = (cnt == 8'd0) ? CSUM_H : DAT_H;
          end
          DAT_H:  state_next = DAT_L;
          DAT_L: begin
            data_wr    = (rtype == REC_DATA);
            state_next = (cnt == 8'd1) ? CSUM_H : DAT_H;
          end
          CSUM_H: state_next = CSUM_L;
          CSUM_L: begin
            rec_end    = 1'b1;
            state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      hex_mode  <= 1'b0;
      hi_nib    <= 4'd0;
      cnt       <= 8'd0;
      rtype     <= 8'd0;
      sum       <= 8'd0;
      addr      <= 16'd0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_data  <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      rec_count <= 16'd0;
    end else begin
      active_q <= dl_active;
      rom_we   <= 1'b0;

      if (active_rise) begin
        hex_mode  <= dl_hex;
        done      <= 1'b0;
        err       <= 1'b0;
        err_code  <= ERR_NONE;
        rec_count <= 16'd0;
        sum       <= 8'd0;
      end

      if (dl_active && !active_rise && !hex_mode && dl_wr) begin
        rom_we   <= 1'b1;
        rom_addr <= dl_addr;
        rom_data <= dl_data;
      end

      if (hex_strobe && state == IDLE && dl_data == CH_COLON) sum <= 8'd0;

      if (hex_strobe && nib_ok) begin
        case (state)
          LEN_H, ADR_3, ADR_1, TYP_H, DAT_H, CSUM_H: hi_nib <= nib;
          LEN_L:  begin cnt <= byte_val;        sum <= sum_new; end
          ADR_2:  begin addr[15:8] <= byte_val; sum <= sum_new; end
          ADR_0:  begin addr[7:0] <= byte_val;  sum <= sum_new; end
          TYP_L:  begin rtype <= byte_val;      sum <= sum_new; end
          DAT_L: begin
            sum  <= sum_new;
            addr <= addr + 16'd1;
            cnt  <= cnt - 8'd1;
          end
          CSUM_L: sum <= sum_new;
          default: ;
        endcase
      end

      if (data_wr) begin
        rom_we   <= 1'b1;
        rom_addr <= addr[ADDR_W-1:0];
        rom_data <= byte_val;
      end

      if (rec_end && !csum_bad) begin
        if (rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
        if (rtype == REC_EOF)      done      <= 1'b1;
      end

      if (bad_char || type_bad || csum_bad) begin
        err <= 1'b1;
        if (!err) begin
          err_code <= bad_char ? ERR_CHAR : (type_bad ? ERR_TYPE : ERR_CSUM);
        end
      end
    end
  end

endmodule

// File: tb/tb_ihex_loader.sv
// Self-checking bench for ihex_loader: table of whole-stream vectors, hand
// sequences for latency / reset / abort corners, and randomized records
// checked against a record-level reference model.
module tb_ihex_loader;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst, dl_active, dl_hex, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          rom_we, busy, done, err;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [1:0]    err_code;
  logic [15:0]   rec_count;

  ihex_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .dl_active(dl_active), .dl_hex(dl_hex), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int offs = 0;
  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wa.push_back(rom_addr);
      wd.push_back(rom_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_str(input string s, input bit b2b);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      dl_wr   = 1'b1;
      dl_data = s[i];
      dl_addr = offs[AW-1:0];
      offs++;
      if (!b2b) begin
        @(negedge clk);
        dl_wr = 1'b0;
      end
    end
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic start_session(input bit hex);
    @(negedge clk);
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    @(negedge clk);
    dl_hex    = hex;
    dl_active = 1'b1;
    @(negedge clk);
    offs = 0;
    wa.delete();
    wd.delete();
  endtask

  task automatic end_session;
    repeat (2) @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string txt;
    bit    b2b;
    int    e_done, e_err, e_code, e_cnt, e_nwr, e_a0, e_d0, e_a1, e_d1;
  } vec_t;
  vec_t vq[$];

  task automatic add(input string t, input bit b, input int dn, input int er, input int cd,
                     input int cn, input int nw, input int a0, input int d0,
                     input int a1, input int d1);
    vec_t v;
    v.txt = t; v.b2b = b; v.e_done = dn; v.e_err = er; v.e_code = cd; v.e_cnt = cn;
    v.e_nwr = nw; v.e_a0 = a0; v.e_d0 = d0; v.e_a1 = a1; v.e_d1 = d1;
    vq.push_back(v);
  endtask

  function automatic string hx(input logic [7:0] v, input bit up);
    string s;
    s = $sformatf("%02x", v);
    if (up) s = s.toupper();
    return s;
  endfunction

  // reference model state for the random run
  logic [AW-1:0] ma[$];
  logic [7:0]    md[$];
  int m_done, m_err, m_code, m_cnt;

  initial begin
    int n0;
    rst = 1'b1; dl_active = 1'b0; dl_hex = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_data", rom_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_rec_count", rec_count, 0);
    rst = 1'b0;

    // raw mode pass-through with 1-cycle latency, back-to-back strobes
    start_session(1'b0);
    dl_wr = 1'b1; dl_addr = 15'd0; dl_data = 8'h11;
    @(negedge clk);
    chk("raw_we0", rom_we, 1);
    chk("raw_wr0", {rom_addr, rom_data}, {15'd0, 8'h11});
    dl_addr = 15'd1; dl_data = 8'h22;
    @(negedge clk);
    dl_wr = 1'b0;
    chk("raw_we1", rom_we, 1);
    chk("raw_wr1", {rom_addr, rom_data}, {15'd1, 8'h22});
    @(negedge clk);
    chk("raw_we_end", rom_we, 0);
    chk("raw_status", {done, err, rec_count}, 0);
    end_session();

    // whole-stream table
    add(":0401000001020304F1:00000001FF",         0, 1,0,0, 2, 4, 'h100,'h01, 'h103,'h04);
    add(":0401000001020304f1\r\n:00000001ff\r\n", 1, 1,0,0, 2, 4, 'h100,'h01, 'h103,'h04);
    add(":02ABCD00abcd0e",                          1, 0,0,0, 1, 2, 'h2BCD,'hAB, 'h2BCE,'hCD);
    add(":0401000001020304F2",                      0, 0,1,2, 0, 4, 'h100,'h01, 'h103,'h04);
    add(":04010G:00000001FF",                       0, 1,1,1, 1, 0, 0,0, 0,0);
    add(":0000000AF6",                              1, 0,1,3, 1, 0, 0,0, 0,0);
    add(":0000000AF7",                              0, 0,1,3, 0, 0, 0,0, 0,0);
    add(":020000041234B4",                          1, 0,0,0, 1, 0, 0,0, 0,0);
    add("x :00000001FF",                            0, 1,1,1, 1, 0, 0,0, 0,0);
    add(":00000001FF:0100000055AA",                 1, 1,0,0, 2, 1, 0,'h55, 0,'h55);
    add(":02FFFF00A5B6A5",                          0, 0,0,0, 1, 2, 'h7FFF,'hA5, 0,'hB6);

    foreach (vq[i]) begin
      start_session(1'b1);
      send_str(vq[i].txt, vq[i].b2b);
      end_session();
      chk($sformatf("v%0d_done", i), done, vq[i].e_done);
      chk($sformatf("v%0d_err", i), err, vq[i].e_err);
      chk($sformatf("v%0d_code", i), err_code, vq[i].e_code);
      chk($sformatf("v%0d_cnt", i), rec_count, vq[i].e_cnt);
      chk($sformatf("v%0d_nwr", i), wa.size(), vq[i].e_nwr);
      chk($sformatf("v%0d_busy", i), busy, 0);
      if (vq[i].e_nwr > 0 && wa.size() > 0) begin
        chk($sformatf("v%0d_first", i), {wa[0], wd[0]}, {vq[i].e_a0[AW-1:0], vq[i].e_d0[7:0]});
        chk($sformatf("v%0d_last", i), {wa[$], wd[$]}, {vq[i].e_a1[AW-1:0], vq[i].e_d1[7:0]});
      end
    end

    // bad character: error one cycle after the strobe, parser back in IDLE
    start_session(1'b1);
    send_str(":04010", 0);
    chk("g_pre_err", err, 0);
    dl_wr = 1'b1; dl_data = "G";
    @(negedge clk);
    dl_wr = 1'b0;
    chk("g_err", {err, err_code}, {1'b1, 2'd1});
    chk("g_busy", busy, 0);
    end_session();

    // unsupported type: code 3 one cycle after TYP_L
    start_session(1'b1);
    send_str(":0000000", 0);
    dl_wr = 1'b1; dl_data = "A";
    @(negedge clk);
    dl_wr = 1'b0;
    chk("typ_err", {err, err_code}, {1'b1, 2'd3});
    chk("typ_busy", busy, 1);
    end_session();

    // hex write latency, then reset mid-record
    start_session(1'b1);
    send_str(":020000001", 0);
    dl_wr = 1'b1; dl_data = "2";
    @(negedge clk);
    dl_wr = 1'b0;
    chk("hx_we", rom_we, 1);
    chk("hx_wr", {rom_addr, rom_data}, {15'd0, 8'h12});
    @(negedge clk);
    chk("hx_we_end", rom_we, 0);
    send_str("3", 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out", {rom_we, rom_addr, rom_data, busy, done, err, err_code, rec_count}, 0);
    n0 = wa.size();
    repeat (5) @(negedge clk);
    chk("mrst_nowr", wa.size(), n0);
    end_session();

    // dl_active falls mid-record: idle next cycle, no error
    start_session(1'b1);
    send_str(":0401", 0);
    chk("abort_busy_pre", busy, 1);
    dl_active = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);

    // randomized records against the record-level model
    start_session(1'b1);
    m_done = 0; m_err = 0; m_code = 0; m_cnt = 0;
    for (int r = 0; r < 30; r++) begin
      logic [7:0]  len, t, cs, s8;
      logic [15:0] a, ai;
      logic [7:0]  d[$];
      bit up, bad;
      string s;
      int k;
      len = 8'($urandom_range(0, 5));
      a   = 16'($urandom);
      k   = $urandom_range(0, 9);
      t   = (k < 5) ? 8'h00 : (k == 5) ? 8'h01 : 8'($urandom_range(2, 7));
      up  = 1'($urandom);
      bad = ($urandom_range(0, 6) == 0);
      d.delete();
      s8  = len + a[15:8] + a[7:0] + t;
      for (int i = 0; i < len; i++) begin
        d.push_back(8'($urandom));
        s8 += d[i];
      end
      cs = 8'd0 - s8;
      if (bad) cs = cs + 8'd1;
      s = {":", hx(len, up), hx(a[15:8], up), hx(a[7:0], up), hx(t, up)};
      foreach (d[i]) s = {s, hx(d[i], up)};
      s = {s, hx(cs, up)};
      case ($urandom_range(0, 3))
        0: s = {s, "\r\n"};
        1: s = {s, " "};
        2: s = {s, "\n"};
        default: ;
      endcase
      if (t == 8'h00) begin
        foreach (d[i]) begin
          ai = a + 16'(i);
          ma.push_back(ai[AW-1:0]);
          md.push_back(d[i]);
        end
      end
      if (!m_err && t > 8'h05) begin m_err = 1; m_code = 3; end
      if (bad) begin
        if (!m_err) m_code = 2;
        m_err = 1;
      end else begin
        m_cnt++;
        if (t == 8'h01) m_done = 1;
      end
      send_str(s, 1'($urandom));
    end
    end_session();
    chk("rnd_nwr", wa.size(), ma.size());
    for (int i = 0; i < ma.size() && i < wa.size(); i++)
      chk($sformatf("rnd_wr%0d", i), {wa[i], wd[i]}, {ma[i], md[i]});
    chk("rnd_done", done, m_done);
    chk("rnd_err", err, m_err);
    chk("rnd_code", err_code, m_code);
    chk("rnd_cnt", rec_count, m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
